// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size, parity helper
// and the common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam int unsigned FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-flop synchroniser, optional 8-sample glitch filter
// (PS2_TX_GLITCH_FILTER_EN) and a one-cycle falling-edge strobe.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
    end
  end

`ifdef PS2_TX_GLITCH_FILTER_EN
  logic [7:0] hist_q;
  logic       stable_q;

  // The level only moves once eight consecutive samples agree on it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q   <= '1;
      stable_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[6:0], s2_q};
      if (&hist_q)
        stable_q <= 1'b1;
      else if (~|hist_q)
        stable_q <= 1'b0;
    end
  end

  assign level_o = stable_q;
  assign fall_o  = stable_q & ~|hist_q;
`else
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      prev_q <= 1'b1;
    else
      prev_q <= s2_q;
  end

  assign level_o = s2_q;
  assign fall_o  = prev_q & ~s2_q;
`endif

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional input glitch filter: define PS2_TX_GLITCH_FILTER_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned TIMEOUT_CYCLES = 375000,
  parameter int unsigned RELEASE_CYCLES = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       PS2C_in,
  input  logic       PS2D_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned RW = $clog2(RELEASE_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  ps2_tx_state_e state_q;
  logic [IW-1:0] inh_q;
  logic [RW-1:0] rel_q;
  logic [TW-1:0] to_q;
  logic [3:0]    bit_q;
  logic [7:0]    data_q;
  logic          par_q;
  logic          c_oe_q, d_oe_q, busy_q, done_q, err_q;

  logic c_lvl, c_fall, d_lvl, d_fall;

  ps2_line_sync u_sync_c (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .line_i  (PS2C_in),
    .level_o (c_lvl),
    .fall_o  (c_fall)
  );

  ps2_line_sync u_sync_d (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .line_i  (PS2D_in),
    .level_o (d_lvl),
    .fall_o  (d_fall)
  );

  logic in_frame;
  assign in_frame = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      inh_q   <= '0;
      rel_q   <= '0;
      to_q    <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (in_frame)
        to_q <= to_q + TW'(1);

      // Timeout overrides whatever the frame logic would do this cycle.
      if (in_frame && (to_q == TW'(TIMEOUT_CYCLES - 1))) begin
        c_oe_q  <= 1'b0;
        d_oe_q  <= 1'b0;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            // The cycle carrying done/err must not re-arm the transmitter.
            if (tx_start && !done_q && !err_q) begin
              data_q  <= tx_data;
              par_q   <= odd_parity(tx_data);
              busy_q  <= 1'b1;
              c_oe_q  <= 1'b1;
              inh_q   <= '0;
              state_q <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
              d_oe_q  <= 1'b1;
              rel_q   <= '0;
              state_q <= REQ;
            end else begin
              inh_q <= inh_q + IW'(1);
            end
          end
          REQ: begin
            if (rel_q == '0)
              c_oe_q <= 1'b0;
            if (rel_q == RW'(RELEASE_CYCLES)) begin
              to_q    <= '0;
              bit_q   <= '0;
              state_q <= SHIFT;
            end else begin
              rel_q <= rel_q + RW'(1);
            end
          end
          SHIFT: begin
            if (c_fall) begin
              bit_q <= bit_q + 4'd1;
              if (bit_q < 4'(FRAME_BITS - 3)) begin
                d_oe_q <= ~data_q[bit_q[2:0]];
              end else if (bit_q == 4'(FRAME_BITS - 3)) begin
                d_oe_q <= ~par_q;
              end else begin
                d_oe_q  <= 1'b0;
                state_q <= ACK;
              end
            end
          end
          ACK: begin
            if (c_fall) begin
              bit_q <= bit_q + 4'd1;
              if (!d_lvl) begin
                state_q <= WAIT_IDLE;
              end else begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          WAIT_IDLE: begin
            if (c_lvl && d_lvl) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 keyboard on the lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 50;
  localparam int unsigned REL  = 5;
  localparam int unsigned TO   = 4000;
  localparam int unsigned HALF = 100;
`ifdef PS2_TX_GLITCH_FILTER_EN
  localparam int unsigned LAT = 11;
`else
  localparam int unsigned LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset_n, tx_start;
  logic [7:0] tx_data;
  logic       PS2C_in, PS2D_in, ps2c_oe, ps2d_oe, busy, done, err;
  logic       dev_clk, dev_dat;

  int unsigned n_chk = 0, n_err = 0;
  int unsigned n_done = 0, n_errp = 0, n_both = 0;
  int unsigned busy_run = 0, last_busy = 0;
  int unsigned inh_run = 0, last_inh = 0, ov_run = 0, last_ov = 0;

  always #20 clk = ~clk;

  assign PS2C_in = dev_clk & ~ps2c_oe;
  assign PS2D_in = dev_dat & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .PS2C_in  (PS2C_in),
    .PS2D_in  (PS2D_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_errp++;
    if (done && err) n_both++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin last_busy = busy_run; busy_run = 0; end
    if (ps2c_oe && !ps2d_oe) inh_run++;
    else if (inh_run != 0) begin last_inh = inh_run; inh_run = 0; end
    if (ps2c_oe && ps2d_oe) ov_run++;
    else if (ov_run != 0) begin last_ov = ov_run; ov_run = 0; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int unsigned w = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && w < INH + 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_req"}, 32'(w < INH + 20), 32'd1);
  endtask

  // Keyboard side: clocks 11 falls, samples each bit at its rising edge.
  task automatic dev_xfer(input string tag, input logic [7:0] exp, input bit ack);
    logic [9:0]  bits;
    int unsigned c;
    wait_req(tag);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bits[k] = PS2D_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (ack) dev_dat = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_clk = 1'b0;
    if (!ack) begin
      c = 0;
      while (!err && c < 40) begin
        @(negedge clk);
        c++;
      end
      check({tag, "_err_lat"}, c, LAT);
      check({tag, "_err_cd"}, {done, ps2c_oe, ps2d_oe, busy}, 4'b0000);
      repeat (HALF - c) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    dev_dat = 1'b1;
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_d%0d", tag, k), 32'(bits[k]), 32'(exp[3'(k)]));
    check({tag, "_par"}, 32'(bits[8]), 32'(~^exp));
    check({tag, "_stop"}, 32'(bits[9]), 32'd1);
  endtask

  task automatic finish_xfer(input string tag, input int unsigned bd, input int unsigned be,
                             input int unsigned ed, input int unsigned ee);
    repeat (20) @(negedge clk);
    check({tag, "_ndone"}, n_done - bd, ed);
    check({tag, "_nerr"}, n_errp - be, ee);
    check({tag, "_idle"}, {busy, ps2c_oe, ps2d_oe}, 3'b000);
  endtask

  initial begin
    #(40 * 120000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned bd, be, c;
    reset_n  = 1'b1;
    tx_start = 1'b0;
    tx_data  = '0;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    #5 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", {ps2c_oe, ps2d_oe, busy, done, err}, 5'b00000);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with ACK, plus inhibit/overlap/busy timing
    bd = n_done; be = n_errp;
    send_start(CMD_SET_LEDS);
    check("led_busy", 32'(busy), 32'd1);
    dev_xfer("led", CMD_SET_LEDS, 1'b1);
    finish_xfer("led", bd, be, 1, 0);
    check("led_inh_len", last_inh, INH);
    check("led_overlap", last_ov, 32'd1);
    check("led_busy_len", 32'(last_busy >= INH + 23 * HALF - 5 && last_busy <= INH + 23 * HALF + 25), 32'd1);

    bd = n_done; be = n_errp;
    send_start(8'h07);
    dev_xfer("b07", 8'h07, 1'b1);
    finish_xfer("b07", bd, be, 1, 0);

    bd = n_done; be = n_errp;
    send_start(8'h00);
    dev_xfer("b00", 8'h00, 1'b1);
    finish_xfer("b00", bd, be, 1, 0);

    // Device withholds ACK
    bd = n_done; be = n_errp;
    send_start(CMD_ECHO);
    dev_xfer("nack", CMD_ECHO, 1'b0);
    finish_xfer("nack", bd, be, 0, 1);

    // Device never clocks
    bd = n_done; be = n_errp;
    send_start(8'h55);
    wait_req("tmo");
    c = 0;
    while (!err && c < REL + TO + 50) begin
      @(negedge clk);
      c++;
    end
    check("tmo_cycles", c, REL + TO);
    check("tmo_lines", {ps2c_oe, ps2d_oe, busy, done}, 4'b0000);
    finish_xfer("tmo", bd, be, 0, 1);

    // Second tx_start mid-frame must be ignored
    bd = n_done; be = n_errp;
    send_start(CMD_SET_LEDS);
    fork
      dev_xfer("mid", CMD_SET_LEDS, 1'b1);
      begin
        repeat (INH + REL + HALF * 8) @(negedge clk);
        send_start(CMD_RESET);
      end
    join
    finish_xfer("mid", bd, be, 1, 0);

    bd = n_done; be = n_errp;
    send_start(CMD_RESET);
    dev_xfer("rst_cmd", CMD_RESET, 1'b1);
    finish_xfer("rst_cmd", bd, be, 1, 0);

    // Reset during bit 4 (D4 of 0xED is 0, so PS2D is being pulled)
    send_start(CMD_SET_LEDS);
    wait_req("arst");
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    check("arst_pre_d4", {busy, ps2d_oe}, 2'b11);
    reset_n = 1'b0;
    #1;
    check("arst_lines", {ps2c_oe, ps2d_oe, busy}, 3'b000);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    bd = n_done; be = n_errp;
    send_start(CMD_SET_LEDS);
    dev_xfer("post", CMD_SET_LEDS, 1'b1);
    finish_xfer("post", bd, be, 1, 0);

    check("done_err_excl", n_both, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
